// File: rtl/ifetch_queue_if.sv
// Fetch-stage bus bundle: imem request/response, redirect, and decoder handshake.
// Handshake rule for both req and out channels: a transfer happens on a rising
// clock edge where valid && ready; valid never depends on ready; the payload is
// held stable while valid is high and ready is low. imem responses and
// redirects carry no ready signal and are always taken when valid.
interface ifetch_queue_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready;

  // Fetch unit side
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc,
    output out_valid, out_inst, out_pc,
    input  out_ready
  );

  // Environment side (imem, branch unit, decoder)
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc,
    input  out_valid, out_inst, out_pc,
    output out_ready
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues sequential word fetches under a credit limit,
// buffers returned instructions with their PCs and hands them to the decoder.
// A redirect flushes the buffer and marks all in-flight responses for discard.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic             clk,
  input logic             reset,
  ifetch_queue_if.master  io_bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;
  localparam logic [SW-1:0] L_DEPTH = SW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;

  // Instruction FIFO (data + pc)
  logic [31:0]   r_inst_mem [DEPTH];
  logic [31:0]   r_pc_mem   [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;

  // Address of every accepted request, consumed in order by responses
  logic [31:0]   r_req_pc_mem [DEPTH];
  logic [AW-1:0] r_req_wr_ptr;
  logic [AW-1:0] r_req_rd_ptr;

  logic [SW-1:0] w_credit_used;
  logic          w_req_valid;
  logic          w_accept;
  logic          w_resp;
  logic          w_resp_drop;
  logic          w_push;
  logic          w_out_valid;
  logic          w_pop;
  logic [CW-1:0] w_outstanding_next;
  logic [31:0]   w_resp_pc;
  logic [31:0]   w_redirect_pc;

  // Every FIFO slot or in-flight request holds one credit, so a response
  // always finds room and the imem never needs back-pressure.
  assign w_credit_used      = SW'(r_count) + SW'(r_outstanding);
  assign w_req_valid        = !reset && !io_bus.redirect_valid && (w_credit_used < L_DEPTH);
  assign w_accept           = w_req_valid && io_bus.imem_req_ready;
  assign w_resp             = io_bus.imem_resp_valid;
  // Stale responses are always older than any post-redirect request, so
  // discarding the first drop_cnt responses removes exactly the stale ones.
  assign w_resp_drop        = w_resp && (io_bus.redirect_valid || (r_drop_cnt != '0));
  assign w_push             = w_resp && !w_resp_drop;
  assign w_out_valid        = (r_count != '0);
  assign w_pop              = w_out_valid && io_bus.out_ready && !io_bus.redirect_valid;
  assign w_outstanding_next = r_outstanding + CW'(w_accept) - CW'(w_resp);
  assign w_resp_pc          = r_req_pc_mem[r_req_rd_ptr];
  assign w_redirect_pc      = io_bus.redirect_pc & 32'hFFFF_FFFC;

  assign io_bus.imem_req_valid = w_req_valid;
  assign io_bus.imem_req_addr  = r_fetch_pc;
  assign io_bus.out_valid      = w_out_valid;
  assign io_bus.out_inst       = r_inst_mem[r_rd_ptr];
  assign io_bus.out_pc         = r_pc_mem[r_rd_ptr];

  // Fetch PC, occupancy, in-flight and discard counters, queue pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_req_wr_ptr  <= '0;
      r_req_rd_ptr  <= '0;
    end else begin
      r_outstanding <= w_outstanding_next;
      if (w_accept) r_req_wr_ptr <= r_req_wr_ptr + PTR_ONE;
      if (w_resp)   r_req_rd_ptr <= r_req_rd_ptr + PTR_ONE;
      if (io_bus.redirect_valid) begin
        r_fetch_pc <= w_redirect_pc;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_drop_cnt <= w_outstanding_next;
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        if (w_resp && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CW'(1);
      end
    end
  end

  // Payload storage; contents are only meaningful behind the valid counters
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_inst_mem[r_wr_ptr] <= io_bus.imem_resp_data;
      r_pc_mem[r_wr_ptr]   <= w_resp_pc;
    end
    if (w_accept) r_req_pc_mem[r_req_wr_ptr] <= r_fetch_pc;
  end

  // A response with nothing in flight means the imem and this unit disagree
  a_resp_has_req: assert property (@(posedge clk) disable iff (reset)
    io_bus.imem_resp_valid |-> (r_outstanding != '0));

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: behavioural in-order imem with per-request latency,
// directed redirect/reset scenarios, and a scoreboard fed with the expected
// {inst, pc} stream of each fetch segment.
module tb_ifetch_queue;
  logic clk = 1'b0;
  logic reset;

  ifetch_queue_if bus_if();

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus_if)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int pops = 0;
  int acc_cnt = 0;
  int resp_sent = 0;
  int cyc = 0;
  int lat = 1;
  bit lat_rand = 1'b0;

  logic [63:0] exp_q[$];
  logic [31:0] pend_addr_q[$];
  int          pend_due_q[$];

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Expected stream of a fetch segment: sequential words, imem data = ~addr
  task automatic push_seq(input logic [31:0] start, input int n);
    logic [31:0] pc;
    pc = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({~pc, pc});
      pc = pc + 32'd4;
    end
  endtask

  task automatic wait_acc(input int n, input string name);
    int k;
    k = 0;
    while (acc_cnt < n && k < 30) begin
      step();
      k++;
    end
    check(name, {31'b0, acc_cnt >= n}, 32'd1);
  endtask

  // ---------------- imem model ----------------
  // Samples the request handshake and drives responses on the falling edge,
  // so everything it drives is stable at the next rising edge.
  initial begin
    bus_if.imem_resp_valid = 1'b0;
    bus_if.imem_resp_data  = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      bus_if.imem_resp_valid = 1'b0;
      if (reset) begin
        pend_addr_q.delete();
        pend_due_q.delete();
      end else begin
        if (pend_addr_q.size() > 0 && pend_due_q[0] <= cyc) begin
          bus_if.imem_resp_valid = 1'b1;
          bus_if.imem_resp_data  = ~pend_addr_q[0];
          void'(pend_addr_q.pop_front());
          void'(pend_due_q.pop_front());
          resp_sent++;
        end
        if (bus_if.imem_req_valid && bus_if.imem_req_ready) begin
          pend_addr_q.push_back(bus_if.imem_req_addr);
          pend_due_q.push_back(cyc + (lat_rand ? int'($urandom_range(1, 4)) : lat));
          acc_cnt++;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!reset && !bus_if.redirect_valid && bus_if.out_valid && bus_if.out_ready) begin
        total++;
        pops++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL scoreboard_extra: got pc=%h inst=%h want nothing", bus_if.out_pc, bus_if.out_inst);
        end else begin
          e = exp_q.pop_front();
          if ({bus_if.out_inst, bus_if.out_pc} !== e) begin
            bad++;
            $display("FAIL scoreboard: got pc=%h inst=%h want pc=%h inst=%h",
                     bus_if.out_pc, bus_if.out_inst, e[31:0], e[63:32]);
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int p0;
    int v;
    bit found;
    reset = 1'b1;
    bus_if.imem_req_ready = 1'b0;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = 32'h0;
    bus_if.out_ready      = 1'b0;
    repeat (3) step();

    // Reset state
    @(negedge clk);
    check("rst_req_valid", {31'b0, bus_if.imem_req_valid}, 32'd0);
    check("rst_out_valid", {31'b0, bus_if.out_valid}, 32'd0);

    // Decoder stalled: exactly DEPTH requests, head 0x0 held
    step();
    reset = 1'b0;
    bus_if.imem_req_ready = 1'b1;
    bus_if.out_ready = 1'b0;
    lat = 1;
    acc_cnt = 0;
    exp_q.delete();
    push_seq(32'h0, 64);
    @(negedge clk);
    check("first_req_valid", {31'b0, bus_if.imem_req_valid}, 32'd1);
    check("first_req_addr", bus_if.imem_req_addr, 32'h0);
    repeat (6) step();
    @(negedge clk);
    check("stall_pc_mid", bus_if.out_pc, 32'h0);
    repeat (6) step();
    @(negedge clk);
    check("stall_acc_cnt", acc_cnt, 32'd4);
    check("stall_req_valid", {31'b0, bus_if.imem_req_valid}, 32'd0);
    check("stall_out_valid", {31'b0, bus_if.out_valid}, 32'd1);
    check("stall_pc_end", bus_if.out_pc, 32'h0);
    check("stall_inst_end", bus_if.out_inst, 32'hFFFF_FFFF);

    // Release: next request is 0x10, then one instruction per cycle
    step();
    bus_if.out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clk);
      if (bus_if.imem_req_valid) found = 1'b1;
    end
    check("release_req_seen", {31'b0, found}, 32'd1);
    check("release_req_addr", bus_if.imem_req_addr, 32'h10);
    v = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus_if.out_valid) v++;
    end
    check("stream_throughput", v, 32'd16);

    // Redirect coincident with a response and a pop
    step();
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc = 32'h200;
    exp_q.delete();
    push_seq(32'h200, 64);
    @(negedge clk);
    check("redir_no_req", {31'b0, bus_if.imem_req_valid}, 32'd0);
    step();
    bus_if.redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_out_valid", {31'b0, bus_if.out_valid}, 32'd0);
    check("redir_req_addr", bus_if.imem_req_addr, 32'h200);
    p0 = pops;
    repeat (12) step();
    check("redir_pops", {31'b0, (pops - p0) >= 8}, 32'd1);

    // Back-to-back redirects: the last one wins, low bits ignored
    step();
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc = 32'h300;
    step();
    bus_if.redirect_pc = 32'h403;
    exp_q.delete();
    push_seq(32'h400, 64);
    step();
    bus_if.redirect_valid = 1'b0;
    @(negedge clk);
    check("b2b_req_addr", bus_if.imem_req_addr, 32'h400);
    p0 = pops;
    repeat (12) step();
    check("b2b_pops", {31'b0, (pops - p0) >= 8}, 32'd1);

    // Two requests in flight (0x8, 0xC) when redirecting to 0x100
    step();
    reset = 1'b1;
    bus_if.out_ready = 1'b0;
    step();
    reset = 1'b0;
    lat = 1;
    acc_cnt = 0;
    exp_q.delete();
    push_seq(32'h0, 2);
    wait_acc(2, "inflight_acc2");
    lat = 6;
    wait_acc(4, "inflight_acc4");
    check("inflight_full", {31'b0, bus_if.imem_req_valid}, 32'd0);
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc = 32'h100;
    lat = 1;
    exp_q.delete();
    push_seq(32'h100, 64);
    step();
    bus_if.redirect_valid = 1'b0;
    bus_if.out_ready = 1'b1;
    p0 = pops;
    repeat (20) step();
    check("inflight_pops", {31'b0, (pops - p0) >= 8}, 32'd1);

    // Wrap at the top of the address space with random ready and latency
    step();
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc = 32'hFFFF_FFFE;
    exp_q.delete();
    push_seq(32'hFFFF_FFFC, 200);
    lat_rand = 1'b1;
    step();
    bus_if.redirect_valid = 1'b0;
    @(negedge clk);
    check("wrap_req_valid", {31'b0, bus_if.imem_req_valid}, 32'd1);
    check("wrap_req_addr", bus_if.imem_req_addr, 32'hFFFF_FFFC);
    p0 = pops;
    for (int i = 0; i < 150; i++) begin
      step();
      bus_if.imem_req_ready = 1'($urandom_range(0, 1));
      bus_if.out_ready = 1'($urandom_range(0, 1));
    end
    check("wrap_pops", {31'b0, (pops - p0) >= 20}, 32'd1);

    // Reset with count=3, outstanding=1
    step();
    lat_rand = 1'b0;
    lat = 1;
    bus_if.imem_req_ready = 1'b1;
    bus_if.out_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    acc_cnt = 0;
    exp_q.delete();
    wait_acc(3, "rst_mid_acc3");
    lat = 10;
    wait_acc(4, "rst_mid_acc4");
    @(negedge clk);
    check("rst_mid_full", {31'b0, bus_if.imem_req_valid}, 32'd0);
    check("rst_mid_head", bus_if.out_pc, 32'h0);
    step();
    reset = 1'b1;
    exp_q.delete();
    push_seq(32'h0, 64);
    @(negedge clk);
    check("rst_mid_req_valid", {31'b0, bus_if.imem_req_valid}, 32'd0);
    step();
    reset = 1'b0;
    lat = 1;
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    check("rst_mid_out_valid", {31'b0, bus_if.out_valid}, 32'd0);
    check("rst_mid_req_addr", bus_if.imem_req_addr, 32'h0);
    p0 = pops;
    repeat (20) step();
    check("rst_mid_pops", {31'b0, (pops - p0) >= 10}, 32'd1);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
